keccak_job_sequencer: RTL and testbench
=======================================

# keccak_job_sequencer

Two-requester job scheduler for the shared adapted Keccak/SHAKE engine. It accepts "absorb one domain-separated seed, squeeze N blocks" jobs from two clients and arbitrates them round-robin. For each granted job it emits, in order, the engine command, the input-side commands and the output-side command. It then holds the engine and the sampler configuration until the job's last output word has transferred, and signals completion to the owning requester.

## Interface
Parameters:
- `BlockCounterSize`, default 9: width of the block-count field. Must equal the engine's block counter width.
- `JOB_W`, default `BlockCounterSize+13`: job word width, fixed by the job format.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req0_job`  in  JOB_W  job word: {whichSampling:3, is128else256:1, sample:1, outNumBlocks:BlockCounterSize, domainByte:8}.
- `req0_isReady`  in  1  job valid.
- `req0_canReceive`  out  1  sequencer accepts req0 this cycle.
- `req0_done`  out  1  one-cycle pulse: req0's job finished.
- `req1_job` / `req1_isReady` / `req1_canReceive` / `req1_done`: same as the req0 ports, for requester 1.
- `k__cmd`  out  BlockCounterSize+5  engine command.
- `k__cmd_isReady`  out  1  engine command valid.
- `k__cmd_canReceive`  in  1  engine accepts the command.
- `k_in__cmd`  out  11  input command: {byteVal:8, skipIsLast:1, CMD:2}.
- `k_in__cmd_isReady`  out  1  input command valid.
- `k_in__cmd_canReceive`  in  1  input side accepts the command.
- `k_out__cmd`  out  2  output command: {skipIsLast:1, sample:1}.
- `k_out__cmd_isReady`  out  1  output command valid.
- `k_out__cmd_canReceive`  in  1  output side accepts the command.
- `config_whichSampling`  out  3  sampler selection. Registered; held stable for the whole job.
- `h__in_isLast_out`  in  1  tap: the last output word of the current stream transfers this cycle.

## Operation
- Transfer rule, all ports: a transfer occurs in a cycle where isReady and canReceive are both high.
- FSM states: IDLE, CMD_K, IN_BYTE, IN_FWD, CMD_OUT, WAIT.
- IDLE:
  - `reqN_canReceive` is high only for the currently granted requester.
  - Grant rule: if exactly one requester is ready, it is granted. If both are ready, the requester not granted last is granted.
  - `lastGrant` is a register, reset to 1, so req0 wins the first tie.
  - On accept: latch the job word, load `config_whichSampling` from whichSampling, update `lastGrant`.
  - If outNumBlocks==0, go to IDLE and pulse `done` for the accepted requester. Otherwise go to CMD_K.
- CMD_K:
  - Drive `k__cmd` = {is128else256, 0 inState, 0 outState, 0 mainIsInElseOut, outNumBlocks, 1}, i.e. 1 input block and outNumBlocks squeezed blocks.
  - Go to IN_BYTE on transfer.
- IN_BYTE: drive `k_in__cmd` = {domainByte, 1, 2'b00} (sendByte, skipIsLast). Go to IN_FWD on transfer.
- IN_FWD: drive `k_in__cmd` = {8'h00, 0, 2'b10} (forward, last enabled). Go to CMD_OUT on transfer.
- CMD_OUT: drive `k_out__cmd` = {0, sample}. Go to WAIT on transfer.
- WAIT:
  - On a sampled `h__in_isLast_out`=1, go to IDLE and pulse `reqN_done` for the owning requester.
  - `h__in_isLast_out` is ignored in every other state.
- Only one of the three command isReady outputs is high in any cycle. Each isReady stays high until its transfer. Command payloads hold stable while isReady is high.
- The latched job word is unaffected by requester inputs changing after accept.

## Timing
- Reset values: state IDLE, all isReady=0, all canReceive=0, both done=0, all command buses 0, `config_whichSampling`=3'b000.
- Accept at edge T; `k__cmd_isReady` is high from cycle T+1.
- With all canReceive held high, the commands transfer in cycles T+1..T+4 and WAIT begins at T+5.
- Job end: `h__in_isLast_out` is high in WAIT cycle L. In cycle L+1, `reqN_done`=1 and the FSM is in IDLE with `canReceive` active, so a new job can be accepted at edge L+1 (back-to-back).
- `config_whichSampling` changes only on an accept edge. It stays valid through the last output word.
- Asynchronous reset mid-job abandons the job, with no done pulse. The engine must share the same `rst`.

## Test plan
- Single job on req0: job {3'b001, 1, 1, 9'd4, 8'h5F}, all canReceive=1.
  - `k__cmd`=14'b1_0_0_0_000000100_1 at T+1; `k_in__cmd` = {8'h5F,1,00} at T+2, then {00,0,10} at T+3; `k_out__cmd`=2'b01 at T+4.
  - `req0_done` one cycle after `h__in_isLast_out`.
- Simultaneous req0/req1 jobs, repeated 4 times: grants alternate 0,1,0,1; each done pulses only on the owner's line.
- Backpressure: `k_in__cmd_canReceive` low for 5 cycles in IN_BYTE → isReady held, payload stable, no advance; then completes.
- outNumBlocks=0 on req1: done pulses the cycle after accept; no command isReady ever asserts.
- `h__in_isLast_out` pulsed during CMD_K and IN_FWD: ignored. A pulse in WAIT finishes the job. `config_whichSampling` is constant from accept to done.
- `rst` low during IN_FWD: outputs return to reset values asynchronously; after release, a req1 tie-break still grants req0 first.

Source files
------------

// File: rtl/keccak_job_sequencer.sv
// Round-robin sequencer for absorb-one-seed / squeeze-N-blocks jobs on the shared Keccak engine.
// Emits engine, input and output commands per job, then holds the engine until the last output word.
//
//   state   | meaning
//   IDLE    | waiting for a job; canReceive offered to the granted requester
//   CMD_K   | engine command pending
//   IN_BYTE | input command pending: send the domain-separation byte
//   IN_FWD  | input command pending: forward the seed, last enabled
//   CMD_OUT | output command pending
//   WAIT    | job running; ends on the last output word
module keccak_job_sequencer #(
  parameter int BlockCounterSize = 9,
  parameter int JOB_W            = BlockCounterSize + 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [JOB_W-1:0]            req0_job,
  input  logic                        req0_isReady,
  output logic                        req0_canReceive,
  output logic                        req0_done,
  input  logic [JOB_W-1:0]            req1_job,
  input  logic                        req1_isReady,
  output logic                        req1_canReceive,
  output logic                        req1_done,
  output logic [BlockCounterSize+4:0] k__cmd,
  output logic                        k__cmd_isReady,
  input  logic                        k__cmd_canReceive,
  output logic [10:0]                 k_in__cmd,
  output logic                        k_in__cmd_isReady,
  input  logic                        k_in__cmd_canReceive,
  output logic [1:0]                  k_out__cmd,
  output logic                        k_out__cmd_isReady,
  input  logic                        k_out__cmd_canReceive,
  output logic [2:0]                  config_whichSampling,
  input  logic                        h__in_isLast_out
);

  localparam int NbLsb     = 8;
  localparam int SampleBit = BlockCounterSize + 8;
  localparam int Is128Bit  = BlockCounterSize + 9;
  localparam int WsLsb     = BlockCounterSize + 10;

  typedef enum logic [2:0] {IDLE, CMD_K, IN_BYTE, IN_FWD, CMD_OUT, WAIT} state_t;

  state_t                 state;
  logic                   owner;
  logic                   last_grant;
  logic [7:0]             job_domain;
  logic                   job_sample;

  logic                   any_ready;
  logic                   grant_sel;
  logic [JOB_W-1:0]       grant_job;
  logic                   accept;
  logic                   grant_zero;

  always_comb begin
    any_ready  = req0_isReady | req1_isReady;
    grant_sel  = (req0_isReady & req1_isReady) ? ~last_grant : req1_isReady;
    grant_job  = grant_sel ? req1_job : req0_job;
    accept     = (state == IDLE) & any_ready;
    grant_zero = (grant_job[NbLsb +: BlockCounterSize] == '0);
  end

  // Accepts are held off while reset is asserted so a pending requester never sees canReceive.
  assign req0_canReceive = rst & accept & ~grant_sel;
  assign req1_canReceive = rst & accept & grant_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      owner                <= 1'b0;
      last_grant           <= 1'b1;
      job_domain           <= '0;
      job_sample           <= 1'b0;
      req0_done            <= 1'b0;
      req1_done            <= 1'b0;
      k__cmd               <= '0;
      k__cmd_isReady       <= 1'b0;
      k_in__cmd            <= '0;
      k_in__cmd_isReady    <= 1'b0;
      k_out__cmd           <= '0;
      k_out__cmd_isReady   <= 1'b0;
      config_whichSampling <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner                <= grant_sel;
            last_grant           <= grant_sel;
            job_domain           <= grant_job[7:0];
            job_sample           <= grant_job[SampleBit];
            config_whichSampling <= grant_job[WsLsb +: 3];
            if (grant_zero) begin
              req0_done <= ~grant_sel;
              req1_done <= grant_sel;
            end else begin
              state          <= CMD_K;
              k__cmd_isReady <= 1'b1;
              k__cmd         <= {grant_job[Is128Bit], 3'b000,
                                 grant_job[NbLsb +: BlockCounterSize], 1'b1};
            end
          end
        end
        CMD_K: begin
          if (k__cmd_canReceive) begin
            k__cmd_isReady    <= 1'b0;
            k__cmd            <= '0;
            k_in__cmd_isReady <= 1'b1;
            k_in__cmd         <= {job_domain, 1'b1, 2'b00};
            state             <= IN_BYTE;
          end
        end
        IN_BYTE: begin
          if (k_in__cmd_canReceive) begin
            k_in__cmd <= {8'h00, 1'b0, 2'b10};
            state     <= IN_FWD;
          end
        end
        IN_FWD: begin
          if (k_in__cmd_canReceive) begin
            k_in__cmd_isReady  <= 1'b0;
            k_in__cmd          <= '0;
            k_out__cmd_isReady <= 1'b1;
            k_out__cmd         <= {1'b0, job_sample};
            state              <= CMD_OUT;
          end
        end
        CMD_OUT: begin
          if (k_out__cmd_canReceive) begin
            k_out__cmd_isReady <= 1'b0;
            k_out__cmd         <= '0;
            state              <= WAIT;
          end
        end
        WAIT: begin
          if (h__in_isLast_out) begin
            req0_done <= ~owner;
            req1_done <= owner;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_job_sequencer.sv
// Scoreboard bench for keccak_job_sequencer: a job-level model predicts grants, commands and done
// pulses; a negedge monitor compares every DUT transfer against the predicted queues.
module tb_keccak_job_sequencer;
  localparam int BCS = 9;
  localparam int JW  = BCS + 13;

  logic            clk = 1'b0;
  logic            rst;
  logic [JW-1:0]   req0_job, req1_job;
  logic            req0_isReady, req1_isReady;
  logic            req0_canReceive, req1_canReceive, req0_done, req1_done;
  logic [BCS+4:0]  k__cmd;
  logic            k__cmd_isReady, k__cmd_canReceive;
  logic [10:0]     k_in__cmd;
  logic            k_in__cmd_isReady, k_in__cmd_canReceive;
  logic [1:0]      k_out__cmd;
  logic            k_out__cmd_isReady, k_out__cmd_canReceive;
  logic [2:0]      config_whichSampling;
  logic            h__in_isLast_out;

  keccak_job_sequencer #(.BlockCounterSize(BCS)) dut (
    .clk(clk), .rst(rst),
    .req0_job(req0_job), .req0_isReady(req0_isReady),
    .req0_canReceive(req0_canReceive), .req0_done(req0_done),
    .req1_job(req1_job), .req1_isReady(req1_isReady),
    .req1_canReceive(req1_canReceive), .req1_done(req1_done),
    .k__cmd(k__cmd), .k__cmd_isReady(k__cmd_isReady), .k__cmd_canReceive(k__cmd_canReceive),
    .k_in__cmd(k_in__cmd), .k_in__cmd_isReady(k_in__cmd_isReady),
    .k_in__cmd_canReceive(k_in__cmd_canReceive),
    .k_out__cmd(k_out__cmd), .k_out__cmd_isReady(k_out__cmd_isReady),
    .k_out__cmd_canReceive(k_out__cmd_canReceive),
    .config_whichSampling(config_whichSampling),
    .h__in_isLast_out(h__in_isLast_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // predicted streams, filled at issue time in predicted grant order
  logic [13:0]   exp_k_q[$];
  logic [10:0]   exp_in_q[$];
  logic [1:0]    exp_out_q[$];
  int            exp_grant_q[$];
  logic [JW-1:0] exp_job_q[$];
  int            owner_q[$];

  int          last_m = 1;
  int          exp_done_next = -1;
  logic [2:0]  cfg_exp = 3'd0;
  int          since_acc = 0;
  int          stage = 0;
  int          done_total = 0;
  bit          acc0, acc1, out_seen, waiting, real_last;
  bit          bp_en, lat_en, force_in_low;
  int          noise_mode = 0;
  int          wait_cnt = 0;
  bit          pk_v, pi_v, po_v;
  logic [13:0] pk;
  logic [10:0] pi;
  logic [1:0]  po;
  int          m_ga, m_g;
  logic [JW-1:0] m_j;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [JW-1:0] mk_job(input int ws, input int i128, input int smp,
                                           input int nb, input int dom);
    return {3'(ws), 1'(i128), 1'(smp), 9'(nb), 8'(dom)};
  endfunction

  task automatic push_job(input int g, input logic [JW-1:0] j);
    int v, nb, dom, smp, i128;
    v    = int'(j);
    dom  = v % 256;
    nb   = (v / 256) % 512;
    smp  = (v / (1 << 17)) % 2;
    i128 = (v / (1 << 18)) % 2;
    exp_grant_q.push_back(g);
    exp_job_q.push_back(j);
    if (nb != 0) begin
      exp_k_q.push_back(14'(i128 * 8192 + nb * 2 + 1));
      exp_in_q.push_back(11'(dom * 8 + 4));
      exp_in_q.push_back(11'd2);
      exp_out_q.push_back(2'(smp));
    end
  endtask

  // mask bit0 = req0, bit1 = req1; both present together is a tie
  task automatic issue(input int mask, input logic [JW-1:0] j0, input logic [JW-1:0] j1);
    int g;
    if (mask == 3) begin
      g = (last_m == 1) ? 0 : 1;
      push_job(g, (g == 1) ? j1 : j0);
      push_job(1 - g, (g == 1) ? j0 : j1);
      last_m = 1 - g;
    end else begin
      g = (mask == 1) ? 0 : 1;
      push_job(g, (g == 1) ? j1 : j0);
      last_m = g;
    end
    if (mask % 2 == 1) begin req0_job = j0; req0_isReady = 1'b1; end
    if (mask >= 2)     begin req1_job = j1; req1_isReady = 1'b1; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0) begin req0_isReady = 1'b0; req0_job = JW'($urandom); acc0 = 1'b0; end
    if (acc1) begin req1_isReady = 1'b0; req1_job = JW'($urandom); acc1 = 1'b0; end
    k__cmd_canReceive     = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    k_in__cmd_canReceive  = force_in_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    k_out__cmd_canReceive = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (out_seen) begin
      waiting  = 1'b1;
      wait_cnt = $urandom_range(0, 3);
      out_seen = 1'b0;
    end
    real_last = 1'b0;
    if (waiting) begin
      if (wait_cnt == 0) begin
        h__in_isLast_out = 1'b1;
        real_last = 1'b1;
        waiting = 1'b0;
      end else begin
        h__in_isLast_out = 1'b0;
        wait_cnt--;
      end
    end else begin
      h__in_isLast_out = (noise_mode == 2) ? 1'b1 :
                         (noise_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_total < target && n < 600) begin
      step();
      n++;
    end
    if (done_total < target) chk("done_timeout", done_total, target);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_k_rdy"},   k__cmd_isReady, 0);
    chk({tag, "_in_rdy"},  k_in__cmd_isReady, 0);
    chk({tag, "_out_rdy"}, k_out__cmd_isReady, 0);
    chk({tag, "_can0"},    req0_canReceive, 0);
    chk({tag, "_can1"},    req1_canReceive, 0);
    chk({tag, "_done0"},   req0_done, 0);
    chk({tag, "_done1"},   req1_done, 0);
    chk({tag, "_k_cmd"},   k__cmd, 0);
    chk({tag, "_in_cmd"},  k_in__cmd, 0);
    chk({tag, "_out_cmd"}, k_out__cmd, 0);
    chk({tag, "_cfg"},     config_whichSampling, 0);
  endtask

  // monitor: all comparisons against predicted values, sampled at the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      since_acc++;
      chk("done0", req0_done, exp_done_next == 0);
      chk("done1", req1_done, exp_done_next == 1);
      if (exp_done_next >= 0) done_total++;
      exp_done_next = -1;
      chk("config", config_whichSampling, cfg_exp);
      chk("cmd_onehot", (int'(k__cmd_isReady) + int'(k_in__cmd_isReady) + int'(k_out__cmd_isReady)) <= 1, 1);
      chk("can_onehot", req0_canReceive & req1_canReceive, 0);
      if (pk_v) begin chk("k_hold_rdy", k__cmd_isReady, 1); chk("k_hold_data", k__cmd, pk); end
      if (pi_v) begin chk("in_hold_rdy", k_in__cmd_isReady, 1); chk("in_hold_data", k_in__cmd, pi); end
      if (po_v) begin chk("out_hold_rdy", k_out__cmd_isReady, 1); chk("out_hold_data", k_out__cmd, po); end
      pk_v = k__cmd_isReady & ~k__cmd_canReceive;         pk = k__cmd;
      pi_v = k_in__cmd_isReady & ~k_in__cmd_canReceive;   pi = k_in__cmd;
      po_v = k_out__cmd_isReady & ~k_out__cmd_canReceive; po = k_out__cmd;
      if (k__cmd_isReady) begin
        if (exp_k_q.size() == 0) chk("k_unexpected", k__cmd_isReady, 0);
        else if (k__cmd_canReceive) begin
          chk("k_cmd", k__cmd, exp_k_q.pop_front());
          stage++;
          if (lat_en) chk("k_latency", since_acc, stage);
        end
      end
      if (k_in__cmd_isReady) begin
        if (exp_in_q.size() == 0) chk("in_unexpected", k_in__cmd_isReady, 0);
        else if (k_in__cmd_canReceive) begin
          chk("in_cmd", k_in__cmd, exp_in_q.pop_front());
          stage++;
          if (lat_en) chk("in_latency", since_acc, stage);
        end
      end
      if (k_out__cmd_isReady) begin
        if (exp_out_q.size() == 0) chk("out_unexpected", k_out__cmd_isReady, 0);
        else if (k_out__cmd_canReceive) begin
          chk("out_cmd", k_out__cmd, exp_out_q.pop_front());
          stage++;
          if (lat_en) chk("out_latency", since_acc, stage);
          out_seen = 1'b1;
        end
      end
      if (real_last && owner_q.size() > 0) exp_done_next = owner_q.pop_front();
      if ((req0_canReceive && req0_isReady) || (req1_canReceive && req1_isReady)) begin
        m_ga = (req1_canReceive && req1_isReady) ? 1 : 0;
        if (exp_grant_q.size() == 0) chk("grant_unexpected", exp_grant_q.size(), 1);
        else begin
          m_g = exp_grant_q.pop_front();
          m_j = exp_job_q.pop_front();
          chk("grant", m_ga, m_g);
          cfg_exp = m_j[21:19];
          if (m_j[16:8] == 9'd0) exp_done_next = m_g;
          else owner_q.push_back(m_g);
        end
        since_acc = 0;
        stage = 0;
        if (m_ga == 1) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end
  end

  initial begin
    int n;
    int mask, nb;
    rst = 1'b0;
    req0_job = '0; req1_job = '0; req0_isReady = 1'b0; req1_isReady = 1'b0;
    k__cmd_canReceive = 1'b1; k_in__cmd_canReceive = 1'b1; k_out__cmd_canReceive = 1'b1;
    h__in_isLast_out = 1'b0;
    bp_en = 1'b0; lat_en = 1'b1; force_in_low = 1'b0;
    #22;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // single job on req0 with no backpressure
    issue(1, mk_job(1, 1, 1, 4, 8'h5F), '0);
    wait_done(done_total + 1);

    // four ties: grants alternate
    for (int r = 0; r < 4; r++) begin
      issue(3, mk_job($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 9), $urandom_range(0, 255)),
               mk_job($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 9), $urandom_range(0, 255)));
      wait_done(done_total + 2);
    end

    // input side stalled for five cycles while the domain byte is offered
    lat_en = 1'b0;
    issue(1, mk_job(6, 0, 1, 2, 8'hA3), '0);
    n = 0;
    while (!k_in__cmd_isReady && n < 50) begin step(); n++; end
    force_in_low = 1'b1;
    k_in__cmd_canReceive = 1'b0;
    repeat (4) step();
    force_in_low = 1'b0;
    wait_done(done_total + 1);
    lat_en = 1'b1;

    // zero-block job on req1
    issue(2, '0, mk_job(3, 1, 0, 0, 8'h11));
    wait_done(done_total + 1);

    // isLast held high everywhere outside WAIT
    noise_mode = 2;
    issue(1, mk_job(7, 0, 0, 3, 8'h06), '0);
    wait_done(done_total + 1);
    noise_mode = 0;
    step();

    // reset during IN_FWD with req1 pending, then a tie after release
    issue(1, mk_job(5, 1, 1, 3, 8'h77), '0);
    n = 0;
    while (stage < 2 && n < 50) begin step(); n++; end
    req1_job = mk_job(2, 0, 1, 1, 8'h33);
    req1_isReady = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    exp_k_q.delete(); exp_in_q.delete(); exp_out_q.delete();
    exp_grant_q.delete(); exp_job_q.delete(); owner_q.delete();
    exp_done_next = -1; cfg_exp = 3'd0; last_m = 1;
    acc0 = 0; acc1 = 0; out_seen = 0; waiting = 0; real_last = 0;
    pk_v = 0; pi_v = 0; po_v = 0; stage = 0;
    h__in_isLast_out = 1'b0;
    req1_isReady = 1'b0;
    issue(3, mk_job(4, 0, 0, 2, 8'h1F), mk_job(2, 0, 1, 1, 8'h33));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_done(done_total + 2);

    // randomized rounds with backpressure and stray isLast pulses
    bp_en = 1'b1; lat_en = 1'b0; noise_mode = 1;
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, 3);
      nb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      issue(mask,
            mk_job($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), nb, $urandom_range(0, 255)),
            mk_job($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12), $urandom_range(0, 255)));
      wait_done(done_total + ((mask == 3) ? 2 : 1));
    end
    noise_mode = 0;
    repeat (3) step();
    chk("queues_drained", exp_k_q.size() + exp_in_q.size() + exp_out_q.size() + exp_grant_q.size() + owner_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
